seq_shift_unit: RTL and testbench

Multi-cycle shift unit for the KGP_RISC datapath that performs logical/arithmetic, left/right shifts of a 32-bit operand by moving one bit position per clock. It accepts the same operand, amount, type and direction encoding as the combinational shift module, so the two are interchangeable behind the ALU shift opcodes. It exists for the low-area, multi-cycle execute path and reports completion through a start/busy/done handshake. The combinational shift module serves as the golden model when verifying this block.

---
 rtl/seq_shift_unit.sv | 129 ++++++++++++
 tb/tb_seq_shift_unit.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/seq_shift_unit.sv
// seq_shift_unit: multi-cycle 32-bit shifter, one bit position per clock.
// Drop-in multi-cycle counterpart of the combinational shift module; same
// operand / amount / type / direction encoding, plus start/busy/done handshake.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   start         request, sampled only in IDLE
//   Input         operand, captured on the accepting edge
//   Shift_Amount  shift distance 0..31, captured on the accepting edge
//   Type          0 = logical, 1 = arithmetic
//   Direction     0 = left, 1 = right
//   Output        registered result, updated only on entry to DONE
//   busy          high in SHIFT and DONE
//   done          one-cycle pulse, high exactly in DONE
module seq_shift_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AMT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] Input,
    input  logic [AMT_W-1:0] Shift_Amount,
    input  logic             Type,
    input  logic             Direction,
    output logic [WIDTH-1:0] Output,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic             typ_q, typ_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] shifted;

    // One-position shift of the working register; arithmetic left equals logical left.
    always_comb begin
        if (dir_q) begin
            shifted = {typ_q & work_q[WIDTH-1], work_q[WIDTH-1:1]};
        end else begin
            shifted = {work_q[WIDTH-2:0], 1'b0};
        end
    end

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            typ_q   <= 1'b0;
            dir_q   <= 1'b0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            typ_q   <= typ_d;
            dir_q   <= dir_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and next-datapath logic; busy/done are registered from the next state.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        typ_d   = typ_q;
        dir_d   = dir_q;
        out_d   = out_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    work_d = Input;
                    cnt_d  = Shift_Amount;
                    typ_d  = Type;
                    dir_d  = Direction;
                    if (Shift_Amount != '0) begin
                        state_d = SHIFT;
                    end else begin
                        // Zero amount: result is the operand itself.
                        state_d = DONE;
                        out_d   = Input;
                    end
                end
            end
            SHIFT: begin
                work_d = shifted;
                cnt_d  = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = DONE;
                    out_d   = shifted;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == SHIFT) || (state_d == DONE);
        done_d = (state_d == DONE);
    end

    assign Output = out_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed and randomized checks for seq_shift_unit against a behavioural
// combinational shift reference.
module tb_seq_shift_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] in_val;
    logic [4:0]  amt;
    logic        typ;
    logic        dir;
    logic [31:0] out_val;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    seq_shift_unit #(.WIDTH(32), .AMT_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .Input        (in_val),
        .Shift_Amount (amt),
        .Type         (typ),
        .Direction    (dir),
        .Output       (out_val),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] v, input logic [4:0] n,
                                              input logic t, input logic d);
        if (!d)     return v << n;
        else if (t) return 32'($signed(v) >>> n);
        else        return v >> n;
    endfunction

    // Called at a negedge with the DUT idle; accept happens on the next posedge.
    task automatic run_op(input string tag, input logic [31:0] v, input logic [4:0] n,
                          input logic t, input logic d, input logic [31:0] exp);
        int cyc;
        int busy_cyc;
        in_val = v; amt = n; typ = t; dir = d; start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        in_val = ~v; amt = ~n; typ = ~t; dir = ~d;   // latched copies must be used
        cyc      = 1;
        busy_cyc = 0;
        while (!done && cyc < 40) begin
            if (busy) busy_cyc++;
            @(negedge clk);
            cyc++;
        end
        if (busy) busy_cyc++;
        check({tag, "_latency"}, 32'(cyc), 32'(n) + 32'd1);
        check({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(n) + 32'd1);
        check({tag, "_out"}, out_val, exp);
        @(negedge clk);
        check({tag, "_done_fall"}, {31'd0, done}, 32'd0);
        check({tag, "_busy_fall"}, {31'd0, busy}, 32'd0);
        check({tag, "_out_hold"}, out_val, exp);
    endtask

    initial begin
        int done_seen;
        logic [31:0] rv;
        logic [4:0]  ra;
        logic        rt, rd;

        rst = 1'b1; start = 1'b0; in_val = '0; amt = '0; typ = 1'b0; dir = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_out",  out_val, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("lsl",        32'd23,          5'd5,  1'b0, 1'b0, 32'd736);
        run_op("lsr",        32'd23,          5'd5,  1'b0, 1'b1, 32'd0);
        run_op("asr_neg",    32'h8000_0017,   5'd5,  1'b1, 1'b1, 32'hFC00_0000);
        run_op("lsr_neg",    32'h8000_0017,   5'd5,  1'b0, 1'b1, 32'h0400_0000);
        run_op("asl",        32'd26,          5'd13, 1'b1, 1'b0, 32'd212992);
        run_op("zero_amt",   32'hDEAD_BEEF,   5'd0,  1'b0, 1'b0, 32'hDEAD_BEEF);
        run_op("lsl_max",    32'h0000_0001,   5'd31, 1'b0, 1'b0, 32'h8000_0000);
        run_op("asr_max",    32'h8000_0000,   5'd31, 1'b1, 1'b1, 32'hFFFF_FFFF);

        // start re-pulsed during SHIFT must be ignored.
        in_val = 32'd23; amt = 5'd31; typ = 1'b0; dir = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        in_val = 32'd1; amt = 5'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_ignore_busy", {31'd0, busy}, 32'd1);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                done_seen++;
                if (done_seen == 1) check("busy_ignore_out", out_val, 32'h8000_0000);
            end
            @(negedge clk);
        end
        check("busy_ignore_done_count", 32'(done_seen), 32'd1);

        // Reset in mid-operation discards the result.
        in_val = 32'h1234_5678; amt = 5'd20; typ = 1'b0; dir = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_out",  out_val, 32'd0);
        done_seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (done) done_seen++;
            @(negedge clk);
        end
        check("midrst_no_done", 32'(done_seen), 32'd0);

        // rst beats start on the same edge; request accepted on the edge after rst drops.
        in_val = 32'd5; amt = 5'd2; start = 1'b1; rst = 1'b1;
        @(negedge clk);
        check("rst_prio_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        run_op("after_rst", 32'd5, 5'd2, 1'b0, 1'b0, 32'd20);

        // Randomized sweep against the reference shift.
        for (int i = 0; i < 20; i++) begin
            rv = $urandom;
            ra = 5'($urandom_range(0, 31));
            rt = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            run_op("rand", rv, ra, rt, rd, ref_shift(rv, ra, rt, rd));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
